// File: rtl/cam_pkg.sv
// Shared opcode and state definitions for the CAM command front-end.
package cam_pkg;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_SEARCH = 2'b01;
  localparam logic [1:0] OP_LEARN  = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    CAM_WRITE  = OP_WRITE,
    CAM_SEARCH = OP_SEARCH,
    CAM_LEARN  = OP_LEARN,
    CAM_RSVD   = OP_RSVD
  } cam_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_SRCH   = 3'd2,
    ST_LRN_WR = 3'd3,
    ST_RESP   = 3'd4
  } cam_ctrl_state_e;

endpackage

// File: rtl/cam_alloc.sv
// Round-robin LEARN entry allocator: next free pointer plus a saturating
// count of how many allocations have been made.
module cam_alloc #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_en,
  output logic [ADDR_WIDTH-1:0] alloc_ptr,
  output logic [ADDR_WIDTH:0]   fill_count
);

  localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] ptr_reg;
  logic [ADDR_WIDTH:0]   fill_reg;

  // Pointer wraps by natural overflow, so after 2^ADDR_WIDTH LEARNs the
  // oldest allocated entry is the next one to be replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg  <= '0;
      fill_reg <= '0;
    end else if (alloc_en) begin
      ptr_reg <= ptr_reg + 1'b1;
      if (fill_reg != FULL)
        fill_reg <= fill_reg + 1'b1;
    end
  end

  assign alloc_ptr  = ptr_reg;
  assign fill_count = fill_reg;

endmodule

// File: rtl/cam_ctrl.sv
// Command front-end for the CAM: sequences write/search pins, samples the
// match result after SEARCH_LAT cycles and returns one response per command.
module cam_ctrl
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 6,
  parameter int SEARCH_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_hit,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  rsp_learned,
  output logic                  rsp_err,
  output logic                  cam_start,
  output logic                  cam_write_enable,
  output logic [DATA_WIDTH-1:0] cam_din,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  input  logic                  cam_match,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr,
  output logic [ADDR_WIDTH:0]   fill_count
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_WR     = ST_WR;
  localparam logic [2:0] S_SRCH   = ST_SRCH;
  localparam logic [2:0] S_LRN_WR = ST_LRN_WR;
  localparam logic [2:0] S_RESP   = ST_RESP;

  localparam int CNT_W = (SEARCH_LAT < 1) ? 1 : $clog2(SEARCH_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SEARCH_LAT);

  logic [2:0]            state_reg, state_next;
  cam_op_e               op_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  rsp_valid_reg, rsp_hit_reg, rsp_learned_reg, rsp_err_reg;
  logic [ADDR_WIDTH-1:0] rsp_addr_reg;
  logic                  alloc_en;
  logic [ADDR_WIDTH-1:0] alloc_ptr;
  logic                  srch_last;

  assign srch_last = (cnt_reg == '0);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_WRITE:            state_next = S_WR;
            OP_SEARCH, OP_LEARN: state_next = S_SRCH;
            default:             state_next = S_RESP;
          endcase
        end
      end
      S_WR:     state_next = S_RESP;
      S_SRCH: begin
        if (srch_last)
          state_next = (op_reg == CAM_LEARN && !cam_match) ? S_LRN_WR : S_RESP;
      end
      S_LRN_WR: state_next = S_RESP;
      S_RESP:   if (rsp_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      op_reg          <= CAM_WRITE;
      data_reg        <= '0;
      addr_reg        <= '0;
      cnt_reg         <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_hit_reg     <= 1'b0;
      rsp_addr_reg    <= '0;
      rsp_learned_reg <= 1'b0;
      rsp_err_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (cmd_valid) begin
            op_reg   <= cam_op_e'(cmd_op);
            data_reg <= cmd_data;
            addr_reg <= cmd_addr;
            cnt_reg  <= CNT_LOAD;
            if (cmd_op == OP_RSVD) begin
              rsp_valid_reg   <= 1'b1;
              rsp_hit_reg     <= 1'b0;
              rsp_addr_reg    <= '0;
              rsp_learned_reg <= 1'b0;
              rsp_err_reg     <= 1'b1;
            end
          end
        end
        S_WR: begin
          rsp_valid_reg   <= 1'b1;
          rsp_hit_reg     <= 1'b0;
          rsp_addr_reg    <= addr_reg;
          rsp_learned_reg <= 1'b0;
          rsp_err_reg     <= 1'b0;
        end
        S_SRCH: begin
          cnt_reg <= cnt_reg - 1'b1;
          // A LEARN miss defers its response to the allocation write.
          if (srch_last && (op_reg != CAM_LEARN || cam_match)) begin
            rsp_valid_reg   <= 1'b1;
            rsp_hit_reg     <= cam_match;
            rsp_addr_reg    <= cam_match ? cam_match_addr : '0;
            rsp_learned_reg <= 1'b0;
            rsp_err_reg     <= 1'b0;
          end
        end
        S_LRN_WR: begin
          rsp_valid_reg   <= 1'b1;
          rsp_hit_reg     <= 1'b0;
          rsp_addr_reg    <= alloc_ptr;
          rsp_learned_reg <= 1'b1;
          rsp_err_reg     <= 1'b0;
        end
        S_RESP: if (rsp_ready) rsp_valid_reg <= 1'b0;
        default: rsp_valid_reg <= 1'b0;
      endcase
    end
  end

  // CAM pins decode straight from state so reset drops them without a clock.
  assign cam_start        = (state_reg == S_SRCH);
  assign cam_write_enable = (state_reg == S_WR) || (state_reg == S_LRN_WR);
  assign cam_din          = (cam_start || cam_write_enable) ? data_reg : '0;
  assign cam_write_addr   = (state_reg == S_WR)     ? addr_reg  :
                            (state_reg == S_LRN_WR) ? alloc_ptr : '0;
  assign alloc_en         = (state_reg == S_LRN_WR);

  assign cmd_ready   = (state_reg == S_IDLE);
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_hit     = rsp_hit_reg;
  assign rsp_addr    = rsp_addr_reg;
  assign rsp_learned = rsp_learned_reg;
  assign rsp_err     = rsp_err_reg;

  cam_alloc #(.ADDR_WIDTH(ADDR_WIDTH)) u_alloc (
    .clk        (clk),
    .rst_n      (rst_n),
    .alloc_en   (alloc_en),
    .alloc_ptr  (alloc_ptr),
    .fill_count (fill_count)
  );

endmodule

// File: tb/tb_cam_ctrl.sv
// Bench for cam_ctrl with a behavioural 1-cycle CAM and a scoreboard of
// expected responses, pin activity and latencies.
module tb_cam_ctrl;

  localparam int DW = 128;
  localparam int AW = 6;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [DW-1:0] cmd_data = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic          rsp_valid, rsp_hit, rsp_learned, rsp_err;
  logic [AW-1:0] rsp_addr;
  logic          rsp_ready = 1'b0;
  logic          cam_start, cam_write_enable;
  logic [DW-1:0] cam_din;
  logic [AW-1:0] cam_write_addr;
  logic          cam_match;
  logic [AW-1:0] cam_match_addr;
  logic [AW:0]   fill_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cam_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEARCH_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_addr(cmd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_addr(rsp_addr), .rsp_learned(rsp_learned), .rsp_err(rsp_err),
    .cam_start(cam_start), .cam_write_enable(cam_write_enable),
    .cam_din(cam_din), .cam_write_addr(cam_write_addr),
    .cam_match(cam_match), .cam_match_addr(cam_match_addr),
    .fill_count(fill_count)
  );

  // Behavioural CAM: registered search result, lowest matching index wins.
  logic [DW-1:0] cam_mem [DEPTH];
  logic          cam_vld [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      cam_mem[i] = '0;
      cam_vld[i] = 1'b0;
    end
    cam_match = 1'b0;
    cam_match_addr = '0;
  end

  always @(posedge clk) begin
    if (cam_write_enable) begin
      cam_mem[cam_write_addr] <= cam_din;
      cam_vld[cam_write_addr] <= 1'b1;
    end
    if (cam_start) begin
      cam_match <= 1'b0;
      cam_match_addr <= '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (cam_vld[i] && cam_mem[i] == cam_din) begin
          cam_match <= 1'b1;
          cam_match_addr <= AW'(i);
        end
      end
    end
  end

  // Reference contents and allocator state used to predict responses.
  logic [DW-1:0] ref_key [DEPTH];
  logic          ref_vld [DEPTH];
  int            ref_ptr = 0;
  int            ref_fill = 0;

  typedef struct {
    logic          hit;
    logic [AW-1:0] addr;
    logic          learned;
    logic          err;
    int            lat;
    int            n_start;
    int            n_we;
    logic [AW-1:0] we_addr;
  } exp_t;

  exp_t sb [$];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_lookup(input logic [DW-1:0] key);
    for (int i = 0; i < DEPTH; i++)
      if (ref_vld[i] && ref_key[i] == key) return i;
    return -1;
  endfunction

  task automatic do_cmd(input logic [1:0] op, input logic [DW-1:0] data,
                        input logic [AW-1:0] addr, input int hold);
    exp_t e;
    exp_t g;
    int idx, ns, nwe, lat;
    logic bad, unstable;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    e = '{hit: 1'b0, addr: '0, learned: 1'b0, err: 1'b0, lat: 0, n_start: 0, n_we: 0, we_addr: '0};
    case (op)
      2'b00: begin
        e.lat = 2; e.n_we = 1; e.addr = addr; e.we_addr = addr;
        ref_key[addr] = data; ref_vld[addr] = 1'b1;
      end
      2'b01: begin
        idx = ref_lookup(data);
        e.lat = 3; e.n_start = 2;
        if (idx >= 0) begin e.hit = 1'b1; e.addr = AW'(idx); end
      end
      2'b10: begin
        idx = ref_lookup(data);
        e.n_start = 2;
        if (idx >= 0) begin
          e.hit = 1'b1; e.addr = AW'(idx); e.lat = 3;
        end else begin
          e.learned = 1'b1; e.addr = AW'(ref_ptr); e.lat = 4;
          e.n_we = 1; e.we_addr = AW'(ref_ptr);
          ref_key[ref_ptr] = data; ref_vld[ref_ptr] = 1'b1;
          ref_ptr = (ref_ptr + 1) % DEPTH;
          if (ref_fill < DEPTH) ref_fill++;
        end
      end
      default: begin
        e.err = 1'b1; e.lat = 1;
      end
    endcase
    sb.push_back(e);

    @(negedge clk);
    check("cmd_ready_idle", DW'(cmd_ready), DW'(1));
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_addr = addr;
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_data = '0; cmd_addr = '0;

    ns = 0; nwe = 0; lat = 0; bad = 1'b0; wa = '0; wd = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (cam_start) begin
        ns++;
        if (cam_din !== data) bad = 1'b1;
      end
      if (cam_write_enable) begin
        nwe++; wa = cam_write_addr; wd = cam_din;
      end
      if (cam_start && cam_write_enable) bad = 1'b1;
      if (!cam_start && !cam_write_enable && cam_din !== '0) bad = 1'b1;
      if (rsp_valid) begin
        lat = c;
        break;
      end
    end
    g = sb.pop_front();
    if (lat == 0) begin
      check("rsp_timeout", DW'(0), DW'(1));
      return;
    end
    check("rsp_hit", DW'(rsp_hit), DW'(g.hit));
    check("rsp_addr", DW'(rsp_addr), DW'(g.addr));
    check("rsp_learned", DW'(rsp_learned), DW'(g.learned));
    check("rsp_err", DW'(rsp_err), DW'(g.err));
    check("latency", DW'(lat), DW'(g.lat));
    check("start_cycles", DW'(ns), DW'(g.n_start));
    check("we_cycles", DW'(nwe), DW'(g.n_we));
    check("pin_rules", DW'(bad), DW'(0));
    check("cmd_ready_busy", DW'(cmd_ready), DW'(0));
    if (g.n_we != 0) begin
      check("we_addr", DW'(wa), DW'(g.we_addr));
      check("we_din", wd, data);
    end

    unstable = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_hit !== g.hit || rsp_addr !== g.addr ||
          rsp_learned !== g.learned || rsp_err !== g.err || cmd_ready !== 1'b0)
        unstable = 1'b1;
    end
    if (hold > 0) check("bp_stable", DW'(unstable), DW'(0));

    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check("rsp_drop", DW'(rsp_valid), DW'(0));
    check("fill_count", DW'(fill_count), DW'(ref_fill));
    $display("cmd op=%0d data=%0h addr=%0d -> hit=%0d addr=%0d learned=%0d err=%0d lat=%0d fill=%0d",
             op, data, addr, rsp_hit, rsp_addr, rsp_learned, rsp_err, lat, fill_count);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ref_key[i] = '0;
      ref_vld[i] = 1'b0;
    end

    // Reset state.
    #12;
    check("rst_cmd_ready", DW'(cmd_ready), DW'(1));
    check("rst_outputs", DW'({rsp_valid, rsp_hit, rsp_learned, rsp_err, cam_start, cam_write_enable}), DW'(0));
    check("rst_din", cam_din, '0);
    check("rst_fill", DW'(fill_count), DW'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-SEARCH drops the command and the CAM strobe at once.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = DW'(32'hCAFE);
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_data = '0;
    @(negedge clk);
    check("mid_start_on", DW'(cam_start), DW'(1));
    #1 rst_n = 1'b0;
    #1 check("mid_start_async", DW'(cam_start), DW'(0));
    repeat (3) @(posedge clk);
    #1 check("mid_no_rsp", DW'(rsp_valid), DW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", DW'(cmd_ready), DW'(1));
    check("post_rst_fill", DW'(fill_count), DW'(0));

    // WRITE then SEARCH hit/miss.
    do_cmd(2'b00, DW'(32'hDEADBEEF), AW'(5), 0);
    do_cmd(2'b01, DW'(32'hDEADBEEF), '0, 0);
    do_cmd(2'b01, DW'(32'h1234), '0, 0);

    // LEARN allocation and re-learn hit.
    do_cmd(2'b10, DW'(32'hA), '0, 0);
    do_cmd(2'b10, DW'(32'hB), '0, 0);
    do_cmd(2'b10, DW'(32'hA), '0, 0);
    check("fill_after_learn", DW'(fill_count), DW'(2));

    // Backpressure and reserved opcode.
    do_cmd(2'b01, DW'(32'hB), '0, 5);
    do_cmd(2'b11, DW'(32'h77), AW'(9), 5);

    // Fill every entry, then one more new key wraps to entry 0.
    for (int i = 0; i < DEPTH - 2; i++)
      do_cmd(2'b10, DW'(32'h1000 + i), '0, 0);
    check("fill_full", DW'(fill_count), DW'(DEPTH));
    do_cmd(2'b10, DW'(32'h5555), '0, 0);
    check("fill_sat", DW'(fill_count), DW'(DEPTH));
    do_cmd(2'b10, DW'(32'h5555), '0, 2);
    do_cmd(2'b01, DW'(32'hA), '0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
